ifid_buffer: RTL and testbench
==============================

IFID_BUFFER -- requirements
Module: ifid_buffer

Interface
REQ-001 Parameter: DEPTH, default 2, number of instruction entries; legal values 2 and 4 only.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 flush  input  1  discard all buffered instructions (redirect from branch/jump).
REQ-005 in_valid  input  1  fetch stage presents an instruction.
REQ-006 in_ready  output  1  buffer accepts an instruction this cycle.
REQ-007 in_instr  input  32  fetched instruction word.
REQ-008 in_pc  input  32  PC of in_instr.
REQ-009 out_valid  output  1  head entry is valid for decode.
REQ-010 out_ready  input  1  decode consumes the head entry this cycle (deasserted on stall).
REQ-011 out_instr  output  32  head instruction; 32'h00000013 (NOP) when out_valid=0.
REQ-012 out_pc  output  32  head PC; 32'h0 when out_valid=0.
REQ-013 iimm_shamt  output  5  out_instr[24:20].
REQ-014 iimm  output  12  out_instr[31:20].
REQ-015 simm  output  12  {out_instr[31:25], out_instr[11:7]}.
REQ-016 bimm  output  12  {out_instr[31], out_instr[7], out_instr[30:25], out_instr[11:8]}.
REQ-017 uimm  output  20  out_instr[31:12].
REQ-018 jimm  output  20  {out_instr[31], out_instr[19:12], out_instr[20], out_instr[30:21]}.
REQ-019 rd, rs1, rs2  output  5 each  out_instr[11:7], [19:15], [24:20].
REQ-020 count  output  3  number of valid entries, 0..DEPTH.

Function
REQ-021 Storage: circular FIFO of DEPTH {instr, pc} entries, read pointer, write pointer, count; pointers wrap modulo DEPTH.
REQ-022 in_ready = (count < DEPTH); combinational from registered count only, independent of out_ready (no full-bypass).
REQ-023 Push when in_valid & in_ready & !flush; entry written at write pointer, write pointer +1.
REQ-024 out_valid = (count != 0); head outputs driven combinationally from the entry at read pointer.
REQ-025 Pop when out_valid & out_ready & !flush; read pointer +1.
REQ-026 Simultaneous push and pop: count unchanged, both pointers advance.
REQ-027 Latency: instruction pushed in cycle N visible on out_* in cycle N+1 (no empty-bypass).
REQ-028 Empty: out_ready ignored, no pop, pointers hold, out_instr = NOP, out_pc = 0.
REQ-029 Full: in_valid ignored, in_instr not stored, stored entries unchanged.
REQ-030 Flush: next edge sets count=0, read pointer=write pointer=0; same-cycle push and pop suppressed.
REQ-031 out_valid=0 for exactly the cycle after flush unless a push occurs in that cycle.
REQ-032 All immediate/register field outputs are pure slices of out_instr; when empty they are slices of the NOP (iimm=0, rd=0, rs1=0, etc.).
REQ-033 Entries are held while out_ready=0 (stall) for any number of cycles; head never changes without a pop.

Reset
REQ-034 On reset assertion (asynchronous): count=0, both pointers=0, out_valid=0, in_ready=1, out_instr=NOP, out_pc=0; storage contents need not be cleared.
REQ-035 Reset asserted mid-operation discards all entries immediately; the first push after deassertion appears at the head one cycle later.
REQ-036 Reset has priority over flush, push and pop.

Verification
REQ-037 Reset, then push 0x00500093 @pc 0x0 with out_ready=1 -> next cycle out_valid=1, iimm=0x005, rd=1, rs1=0; following cycle count=0, out_instr=NOP.
REQ-038 out_ready=0, push 0x00000013 @0x0, 0x00100113 @0x4, third in_valid held -> in_ready=0 after two pushes, count=2, head pc 0x0 stable; release out_ready -> pcs 0x0, 0x4, then third instruction emerge in order.
REQ-039 Head 0xFE000EE3 (beq, negative offset) -> bimm=0xFFE (bit 11=1, bit 10=1, bits 9:4=0x3F, bits 3:0=0xE); head 0x8000006F -> jimm=0x80000, uimm=0x80000.
REQ-040 Full buffer, flush=1 with in_valid=1 and out_ready=1 -> next cycle count=0, out_valid=0, the flushed-cycle instruction not stored.
REQ-041 Continuous in_valid=1/out_ready=1 across 2*DEPTH+1 instructions -> one instruction per cycle after first, pointers wrap, order preserved, count stays 1.
REQ-042 count=2, assert reset between edges -> out_valid=0 and count=0 before next clock edge.

Source files
------------

// File: rtl/ifid_buffer.sv
// ifid_buffer: fetch-to-decode instruction FIFO with decoded immediate/register fields
module ifid_buffer #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic [4:0]  iimm_shamt,
  output logic [11:0] iimm,
  output logic [11:0] simm,
  output logic [11:0] bimm,
  output logic [19:0] uimm,
  output logic [19:0] jimm,
  output logic [4:0]  rd,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [2:0]  count
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [2:0] DEPTH_C = 3'(DEPTH);
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic [31:0] instr_q [DEPTH];
  logic [31:0] pc_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [2:0] count_q, count_d;
  logic push, pop;
  assign in_ready  = count_q < DEPTH_C;
  assign out_valid = count_q != 3'd0;
  assign push = in_valid & in_ready & ~flush;
  assign pop  = out_valid & out_ready & ~flush;
  assign count = count_q;
  assign out_instr = out_valid ? instr_q[rd_ptr_q] : NOP;
  assign out_pc    = out_valid ? pc_q[rd_ptr_q] : 32'h0;
  assign iimm_shamt = out_instr[24:20];
  assign iimm = out_instr[31:20];
  assign simm = {out_instr[31:25], out_instr[11:7]};
  assign bimm = {out_instr[31], out_instr[7], out_instr[30:25], out_instr[11:8]};
  assign uimm = out_instr[31:12];
  assign jimm = {out_instr[31], out_instr[19:12], out_instr[20], out_instr[30:21]};
  assign rd  = out_instr[11:7];
  assign rs1 = out_instr[19:15];
  assign rs2 = out_instr[24:20];
  // next pointers and occupancy; flush returns everything to the empty origin
  always_comb begin
    rd_ptr_d = flush ? '0 : (pop ? rd_ptr_q + PW'(1) : rd_ptr_q);
    wr_ptr_d = flush ? '0 : (push ? wr_ptr_q + PW'(1) : wr_ptr_q);
    count_d  = flush ? 3'd0 :
               (push & ~pop) ? count_q + 3'd1 :
               (pop & ~push) ? count_q - 3'd1 : count_q;
  end
  // control state, cleared asynchronously
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= 3'd0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end
  // entry storage, contents are don't-care until written
  always_ff @(posedge clk) begin
    if (push) begin
      instr_q[wr_ptr_q] <= in_instr;
      pc_q[wr_ptr_q]    <= in_pc;
    end
  end
endmodule

// File: tb/tb_ifid_buffer.sv
// tb_ifid_buffer: directed checks of the fetch/decode instruction buffer
module tb_ifid_buffer;
  logic clk = 1'b0, reset = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] in_instr = '0, in_pc = '0;
  logic in_ready, out_valid;
  logic [31:0] out_instr, out_pc;
  logic [4:0] iimm_shamt, rd, rs1, rs2;
  logic [11:0] iimm, simm, bimm;
  logic [19:0] uimm, jimm;
  logic [2:0] count;
  int checks = 0, errors = 0;
  ifid_buffer #(.DEPTH(2)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
    .iimm_shamt(iimm_shamt), .iimm(iimm), .simm(simm), .bimm(bimm), .uimm(uimm), .jimm(jimm),
    .rd(rd), .rs1(rs1), .rs2(rs2), .count(count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc);
    in_valid = v;
    in_instr = instr;
    in_pc = pc;
  endtask
  initial begin
    #2;
    chk("rst_count", 32'(count), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_instr", out_instr, 32'h13);
    chk("rst_out_pc", out_pc, 0);
    chk("rst_iimm", 32'(iimm), 0);
    chk("rst_rd", 32'(rd), 0);
    cyc();
    reset = 1'b0;
    out_ready = 1'b1;
    drive(1'b1, 32'h0050_0093, 32'h0);
    cyc();
    drive(1'b0, 32'h0, 32'h0);
    chk("addi_valid", 32'(out_valid), 1);
    chk("addi_instr", out_instr, 32'h0050_0093);
    chk("addi_iimm", 32'(iimm), 32'h005);
    chk("addi_rd", 32'(rd), 1);
    chk("addi_rs1", 32'(rs1), 0);
    chk("addi_count", 32'(count), 1);
    cyc();
    chk("addi_pop_count", 32'(count), 0);
    chk("addi_pop_instr", out_instr, 32'h13);
    out_ready = 1'b0;
    drive(1'b1, 32'h0000_0013, 32'h0);
    cyc();
    chk("stall_count1", 32'(count), 1);
    chk("stall_ready1", 32'(in_ready), 1);
    drive(1'b1, 32'h0010_0113, 32'h4);
    cyc();
    chk("stall_count2", 32'(count), 2);
    chk("stall_full_ready", 32'(in_ready), 0);
    chk("stall_head_pc", out_pc, 32'h0);
    drive(1'b1, 32'h0020_0193, 32'h8);
    cyc();
    chk("full_hold_count", 32'(count), 2);
    chk("full_hold_pc", out_pc, 32'h0);
    chk("full_hold_instr", out_instr, 32'h13);
    out_ready = 1'b1;
    cyc();
    chk("drain_pc4", out_pc, 32'h4);
    chk("drain_count", 32'(count), 1);
    cyc();
    chk("drain_pc8", out_pc, 32'h8);
    chk("drain_instr3", out_instr, 32'h0020_0193);
    drive(1'b0, 32'h0, 32'h0);
    cyc();
    chk("drain_empty", 32'(out_valid), 0);
    out_ready = 1'b0;
    drive(1'b1, 32'hFE00_0EE3, 32'h10);
    cyc();
    chk("beq_bimm", 32'(bimm), 32'hFFE);
    chk("beq_simm", 32'(simm), 32'hFFD);
    chk("beq_rs2", 32'(rs2), 0);
    drive(1'b1, 32'h8000_006F, 32'h14);
    cyc();
    chk("beq_head_stable", out_instr, 32'hFE00_0EE3);
    drive(1'b0, 32'h0, 32'h0);
    out_ready = 1'b1;
    cyc();
    chk("jal_jimm", 32'(jimm), 32'h80000);
    chk("jal_uimm", 32'(uimm), 32'h80000);
    chk("jal_rd", 32'(rd), 0);
    chk("jal_pc", out_pc, 32'h14);
    cyc();
    chk("jal_popped", 32'(count), 0);
    out_ready = 1'b0;
    drive(1'b1, 32'h0000_1111, 32'h20);
    cyc();
    drive(1'b1, 32'h0000_2222, 32'h24);
    cyc();
    chk("pre_flush_full", 32'(count), 2);
    flush = 1'b1;
    out_ready = 1'b1;
    drive(1'b1, 32'h0000_3333, 32'h28);
    cyc();
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    chk("flush_count", 32'(count), 0);
    chk("flush_valid", 32'(out_valid), 0);
    chk("flush_instr", out_instr, 32'h13);
    chk("flush_pc", out_pc, 0);
    chk("flush_ready", 32'(in_ready), 1);
    cyc();
    chk("flush_not_stored", 32'(count), 0);
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 32'h100 + 32'(i), 32'(4 * i));
      cyc();
      chk("stream_valid", 32'(out_valid), 1);
      chk("stream_pc", out_pc, 32'(4 * i));
      chk("stream_instr", out_instr, 32'h100 + 32'(i));
      chk("stream_count", 32'(count), 1);
    end
    drive(1'b0, 32'h0, 32'h0);
    cyc();
    chk("stream_empty", 32'(count), 0);
    out_ready = 1'b0;
    drive(1'b1, 32'h0000_4444, 32'h40);
    cyc();
    drive(1'b1, 32'h0000_5555, 32'h44);
    cyc();
    drive(1'b0, 32'h0, 32'h0);
    chk("pre_reset_count", 32'(count), 2);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_count", 32'(count), 0);
    chk("async_rst_valid", 32'(out_valid), 0);
    chk("async_rst_ready", 32'(in_ready), 1);
    chk("async_rst_instr", out_instr, 32'h13);
    cyc();
    reset = 1'b0;
    drive(1'b1, 32'h0000_6666, 32'h50);
    cyc();
    drive(1'b0, 32'h0, 32'h0);
    chk("post_rst_valid", 32'(out_valid), 1);
    chk("post_rst_pc", out_pc, 32'h50);
    chk("post_rst_count", 32'(count), 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
